// File: rtl/line_raster_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_raster_if                                                       |
// | Command and pixel-write bundle between the command controller, the   |
// | line_raster draw stage and the framebuffer write port.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface line_raster_if;
  // Command side
  logic        iGo;
  logic        iFlip;
  logic        iPolyline;
  logic [8:0]  iColor;
  logic [7:0]  iX0;
  logic [7:0]  iY0;
  logic [7:0]  iX1;
  logic [7:0]  iY1;
  logic        oDone;
  // Framebuffer write port
  logic        oWrEn;
  logic [16:0] oWrAddr;
  logic [8:0]  oWrData;
  logic        iWrReady;
  logic        oFrontBuf;

  // Driver of commands and write-ready (controller / framebuffer side)
  modport master (
    output iGo, iFlip, iPolyline, iColor, iX0, iY0, iX1, iY1, iWrReady,
    input  oDone, oWrEn, oWrAddr, oWrData, oFrontBuf
  );

  // The draw stage itself
  modport slave (
    input  iGo, iFlip, iPolyline, iColor, iX0, iY0, iX1, iY1, iWrReady,
    output oDone, oWrEn, oWrAddr, oWrData, oFrontBuf
  );
endinterface
`default_nettype wire

// File: rtl/line_raster.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_raster                                                          |
// | Rasterises one primitive per go pulse into a double-buffered         |
// | framebuffer: Bresenham line segments, or a buffer flip followed by   |
// | a full clear of the new back buffer. One pixel per accepted write.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module line_raster #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 160
) (
  input  wire logic    iClk,
  input  wire logic    iRst,
  line_raster_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LINE_INIT = 2'd1,
    S_LINE      = 2'd2,
    S_CLEAR     = 2'd3
  } state_t;

  localparam logic [8:0] W_LIM  = 9'(WIDTH);
  localparam logic [8:0] H_LIM  = 9'(HEIGHT);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  state_t            state_q,  state_d;
  logic [8:0]        color_q,  color_d;
  logic [7:0]        x0_q,     x0_d;
  logic [7:0]        y0_q,     y0_d;
  logic [7:0]        x1_q,     x1_d;
  logic [7:0]        y1_q,     y1_d;
  logic [7:0]        cur_x_q,  cur_x_d;
  logic [7:0]        cur_y_q,  cur_y_d;
  logic signed [9:0] dx_q,     dx_d;
  logic signed [9:0] dy_q,     dy_d;
  logic signed [9:0] err_q,    err_d;
  logic              sx_neg_q, sx_neg_d;
  logic              sy_neg_q, sy_neg_d;
  logic              done_q,   done_d;
  logic              wr_en_q,  wr_en_d;
  logic [16:0]       wr_addr_q, wr_addr_d;
  logic [8:0]        wr_data_q, wr_data_d;
  logic              front_q,  front_d;

  // Bresenham helpers
  logic [7:0]         adx;
  logic [7:0]         ady;
  logic signed [10:0] e2;
  logic signed [10:0] dx_ext;
  logic signed [10:0] dy_ext;
  logic [7:0]         step_x;
  logic [7:0]         step_y;
  logic signed [9:0]  step_err;
  logic [7:0]         clr_x;
  logic [7:0]         clr_y;
  logic               line_accept;

  // A pixel outside the visible area is stepped over without a write.
  function automatic logic in_bounds(input logic [7:0] x, input logic [7:0] y);
    return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  endfunction

  // Endpoint deltas and the next Bresenham position from the current one.
  always_comb begin
    adx      = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady      = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    e2       = {err_q, 1'b0};
    dx_ext   = {dx_q[9], dx_q};
    dy_ext   = {dy_q[9], dy_q};
    step_x   = cur_x_q;
    step_y   = cur_y_q;
    step_err = err_q;
    if (e2 >= dy_ext) begin
      step_err = step_err + dy_q;
      step_x   = sx_neg_q ? (cur_x_q - 8'd1) : (cur_x_q + 8'd1);
    end
    if (e2 <= dx_ext) begin
      step_err = step_err + dx_q;
      step_y   = sy_neg_q ? (cur_y_q - 8'd1) : (cur_y_q + 8'd1);
    end
  end

  // Next raster position for the row-major clear sweep.
  always_comb begin
    clr_x = cur_x_q + 8'd1;
    clr_y = cur_y_q;
    if (cur_x_q == X_LAST) begin
      clr_x = 8'd0;
      clr_y = cur_y_q + 8'd1;
    end
  end

  // A clipped pixel has no write pending, so it advances unconditionally.
  assign line_accept = wr_en_q ? bus.iWrReady : 1'b1;

  // Next-state and registered-output computation for the draw sequencer.
  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    sx_neg_d  = sx_neg_q;
    sy_neg_d  = sy_neg_q;
    done_d    = 1'b0;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    front_d   = front_q;

    case (state_q)
      S_IDLE: begin
        done_d  = 1'b1;
        wr_en_d = 1'b0;
        if (bus.iGo) begin
          color_d = bus.iColor;
          x0_d    = bus.iX0;
          y0_d    = bus.iY0;
          x1_d    = bus.iX1;
          y1_d    = bus.iY1;
          done_d  = 1'b0;
          if (bus.iFlip) begin
            // The old front becomes the back buffer being cleared.
            front_d   = ~front_q;
            state_d   = S_CLEAR;
            cur_x_d   = 8'd0;
            cur_y_d   = 8'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = {front_q, 8'd0, 8'd0};
            wr_data_d = bus.iColor;
          end else if (bus.iPolyline) begin
            state_d = S_LINE_INIT;
          end
        end
      end

      S_LINE_INIT: begin
        dx_d      = $signed({2'b00, adx});
        dy_d      = -$signed({2'b00, ady});
        err_d     = $signed({2'b00, adx}) - $signed({2'b00, ady});
        sx_neg_d  = (x1_q < x0_q);
        sy_neg_d  = (y1_q < y0_q);
        cur_x_d   = x0_q;
        cur_y_d   = y0_q;
        wr_en_d   = in_bounds(x0_q, y0_q);
        wr_addr_d = {~front_q, y0_q, x0_q};
        wr_data_d = color_q;
        state_d   = S_LINE;
      end

      S_LINE: begin
        if (line_accept) begin
          if ((cur_x_q == x1_q) && (cur_y_q == y1_q)) begin
            wr_en_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cur_x_d   = step_x;
            cur_y_d   = step_y;
            err_d     = step_err;
            wr_en_d   = in_bounds(step_x, step_y);
            wr_addr_d = {~front_q, step_y, step_x};
          end
        end
      end

      S_CLEAR: begin
        if (bus.iWrReady) begin
          if ((cur_x_q == X_LAST) && (cur_y_q == Y_LAST)) begin
            wr_en_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cur_x_d   = clr_x;
            cur_y_d   = clr_y;
            wr_addr_d = {~front_q, clr_y, clr_x};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any primitive in flight.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      color_q   <= 9'd0;
      x0_q      <= 8'd0;
      y0_q      <= 8'd0;
      x1_q      <= 8'd0;
      y1_q      <= 8'd0;
      cur_x_q   <= 8'd0;
      cur_y_q   <= 8'd0;
      dx_q      <= 10'sd0;
      dy_q      <= 10'sd0;
      err_q     <= 10'sd0;
      sx_neg_q  <= 1'b0;
      sy_neg_q  <= 1'b0;
      done_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 17'd0;
      wr_data_q <= 9'd0;
      front_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      color_q   <= color_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      err_q     <= err_d;
      sx_neg_q  <= sx_neg_d;
      sy_neg_q  <= sy_neg_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      front_q   <= front_d;
    end
  end

  assign bus.oDone     = done_q;
  assign bus.oWrEn     = wr_en_q;
  assign bus.oWrAddr   = wr_addr_q;
  assign bus.oWrData   = wr_data_q;
  assign bus.oFrontBuf = front_q;

endmodule
`default_nettype wire

// File: tb/tb_line_raster.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_line_raster                                                       |
// | Directed and model-compared tests for the line_raster draw stage.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_line_raster;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_raster_if bus();

  line_raster #(.WIDTH(240), .HEIGHT(160)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic        back_bit = 1'b1;
  logic [25:0] wr_q[$];
  logic [16:0] exp_q[$];

  // Reference Bresenham with clipping; fills exp_q with target addresses.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int n = 0; n < 600; n++) begin
      if (x < 240 && y < 160) exp_q.push_back({back_bit, y[7:0], x[7:0]});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Issues one primitive and records every accepted write into wr_q.
  task automatic run_prim(input logic f, input logic p, input logic [8:0] col,
                          input logic [7:0] a0, input logic [7:0] b0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input int rdy_mode, input int inject_at,
                          output int done_low, output int stall_err, output int timed_out);
    logic        prev_en, prev_rdy;
    logic [16:0] prev_addr;
    logic [8:0]  prev_data;
    int          cyc;
    wr_q.delete();
    done_low = 0; stall_err = 0; timed_out = 1;
    prev_en = 1'b0; prev_rdy = 1'b1; prev_addr = '0; prev_data = '0;
    @(negedge clk);
    bus.iGo = 1'b1; bus.iFlip = f; bus.iPolyline = p; bus.iColor = col;
    bus.iX0 = a0; bus.iY0 = b0; bus.iX1 = a1; bus.iY1 = b1;
    bus.iWrReady = 1'b1;
    for (cyc = 0; cyc < 50000; cyc++) begin
      @(negedge clk);
      bus.iGo = 1'b0; bus.iFlip = 1'b0; bus.iPolyline = 1'b0;
      if (bus.oDone) begin timed_out = 0; break; end
      done_low++;
      if (cyc == inject_at) begin
        bus.iGo = 1'b1; bus.iPolyline = 1'b1; bus.iColor = 9'h055;
      end
      if (prev_en && !prev_rdy &&
          (bus.oWrEn !== 1'b1 || bus.oWrAddr !== prev_addr || bus.oWrData !== prev_data))
        stall_err++;
      bus.iWrReady = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (bus.oWrEn && bus.iWrReady) wr_q.push_back({bus.oWrAddr, bus.oWrData});
      prev_en = bus.oWrEn; prev_rdy = bus.iWrReady;
      prev_addr = bus.oWrAddr; prev_data = bus.oWrData;
    end
    bus.iWrReady = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.oDone !== 1'b1) begin errors++; $display("FAIL reset_done got=%b want=1", bus.oDone); end
    checks++; if (bus.oWrEn !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b want=0", bus.oWrEn); end
    checks++; if (bus.oWrAddr !== 17'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", bus.oWrAddr); end
    checks++; if (bus.oWrData !== 9'd0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.oWrData); end
    checks++; if (bus.oFrontBuf !== 1'b0) begin errors++; $display("FAIL reset_front got=%b want=0", bus.oFrontBuf); end
    rst = 1'b0;
  endtask

  task automatic test_single_pixel();
    int dl, se, to;
    logic [25:0] e;
    run_prim(1'b0, 1'b1, 9'h0AA, 8'd5, 8'd5, 8'd5, 8'd5, 0, -1, dl, se, to);
    e = {1'b1, 8'd5, 8'd5, 9'h0AA};
    checks++; if (to !== 0) begin errors++; $display("FAIL single_timeout got=%0d want=0", to); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL single_count got=%0d want=1", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== e) begin errors++; $display("FAIL single_write got=%h want=%h", wr_q[0], e); end
    end
    checks++; if (dl !== 3) begin errors++; $display("FAIL single_done_low got=%0d want=3", dl); end
  endtask

  task automatic test_noop();
    int dl, se, to;
    run_prim(1'b0, 1'b0, 9'h001, 8'd1, 8'd1, 8'd9, 8'd9, 0, -1, dl, se, to);
    checks++; if (dl !== 1 || wr_q.size() !== 0)
      begin errors++; $display("FAIL noop got=done_low %0d writes %0d want=1 0", dl, wr_q.size()); end
  endtask

  task automatic test_horizontal();
    int dl, se, to;
    logic [25:0] e;
    run_prim(1'b0, 1'b1, 9'h011, 8'd0, 8'd0, 8'd3, 8'd0, 0, -1, dl, se, to);
    checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL horiz_count got=%0d want=4", wr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = {1'b1, 8'd0, 8'(i), 9'h011};
      checks++; if (wr_q[i] !== e) begin errors++; $display("FAIL horiz_px%0d got=%h want=%h", i, wr_q[i], e); end
    end
    checks++; if (dl !== 6) begin errors++; $display("FAIL horiz_consecutive got=%0d want=6", dl); end
    run_prim(1'b0, 1'b1, 9'h022, 8'd3, 8'd0, 8'd0, 8'd0, 0, -1, dl, se, to);
    checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL horiz_rev_count got=%0d want=4", wr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = {1'b1, 8'd0, 8'(3 - i), 9'h022};
      checks++; if (wr_q[i] !== e) begin errors++; $display("FAIL horiz_rev_px%0d got=%h want=%h", i, wr_q[i], e); end
    end
  endtask

  task automatic test_steep();
    int dl, se, to;
    int xs[6] = '{0, 0, 1, 1, 2, 2};
    logic [25:0] e;
    run_prim(1'b0, 1'b1, 9'h133, 8'd0, 8'd0, 8'd2, 8'd5, 0, -1, dl, se, to);
    checks++; if (wr_q.size() !== 6) begin errors++; $display("FAIL steep_count got=%0d want=6", wr_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      e = {1'b1, 8'(i), 8'(xs[i]), 9'h133};
      checks++; if (wr_q[i] !== e) begin errors++; $display("FAIL steep_px%0d got=%h want=%h", i, wr_q[i], e); end
    end
  endtask

  // Random short segments (some straddling the clip edges) against the model.
  task automatic test_random_lines(input int n_seg, input int rdy_mode);
    int dl, se, to, x0, y0, x1, y1, bad;
    logic [8:0] col;
    for (int s = 0; s < n_seg; s++) begin
      x0 = $urandom_range(0, 255); y0 = $urandom_range(0, 255);
      x1 = x0 + $urandom_range(0, 24) - 12; y1 = y0 + $urandom_range(0, 24) - 12;
      if (x1 < 0) x1 = 0; if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0; if (y1 > 255) y1 = 255;
      col = 9'($urandom);
      model_line(x0, y0, x1, y1);
      run_prim(1'b0, 1'b1, col, 8'(x0), 8'(y0), 8'(x1), 8'(y1), rdy_mode, -1, dl, se, to);
      bad = -1;
      if (wr_q.size() != exp_q.size()) bad = 0;
      else for (int i = 0; i < exp_q.size(); i++)
        if (wr_q[i] !== {exp_q[i], col} && bad < 0) bad = i;
      checks++;
      if (to != 0 || bad >= 0) begin
        errors++;
        $display("FAIL rand_seg%0d (%0d,%0d)-(%0d,%0d) got=%0d writes want=%0d writes, first diff %0d",
                 s, x0, y0, x1, y1, wr_q.size(), exp_q.size(), bad);
      end
      if (rdy_mode != 0) begin
        checks++; if (se !== 0) begin errors++; $display("FAIL stall_hold seg%0d got=%0d unstable want=0", s, se); end
      end
    end
  endtask

  task automatic test_backpressure();
    int dl, se, to;
    int xs[6] = '{0, 0, 1, 1, 2, 2};
    logic [25:0] e;
    int bad;
    run_prim(1'b0, 1'b1, 9'h0F0, 8'd0, 8'd0, 8'd2, 8'd5, 1, -1, dl, se, to);
    bad = (wr_q.size() != 6) ? 0 : -1;
    if (bad < 0) for (int i = 0; i < 6; i++) begin
      e = {1'b1, 8'(i), 8'(xs[i]), 9'h0F0};
      if (wr_q[i] !== e && bad < 0) bad = i;
    end
    checks++; if (bad >= 0) begin errors++; $display("FAIL bp_steep got=%0d writes (diff at %0d) want=6 exact", wr_q.size(), bad); end
    checks++; if (se !== 0) begin errors++; $display("FAIL bp_hold got=%0d want=0", se); end
    test_random_lines(200, 1);
  endtask

  task automatic test_flip();
    int dl, se, to, bad;
    logic [25:0] e;
    run_prim(1'b1, 1'b0, 9'h1FF, 8'd0, 8'd0, 8'd0, 8'd0, 0, 1000, dl, se, to);
    back_bit = 1'b0;
    checks++; if (bus.oFrontBuf !== 1'b1) begin errors++; $display("FAIL flip_front got=%b want=1", bus.oFrontBuf); end
    checks++; if (to !== 0 || wr_q.size() !== 38400)
      begin errors++; $display("FAIL flip_count got=%0d timeout=%0d want=38400", wr_q.size(), to); end
    else begin
      bad = -1;
      for (int i = 0; i < 38400; i++) begin
        e = {1'b0, 8'(i / 240), 8'(i % 240), 9'h1FF};
        if (wr_q[i] !== e && bad < 0) bad = i;
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL flip_order idx=%0d got=%h", bad, wr_q[bad]); end
      e = {1'b0, 8'd159, 8'd239, 9'h1FF};
      checks++; if (wr_q[38399] !== e) begin errors++; $display("FAIL flip_last got=%h want=%h", wr_q[38399], e); end
    end
    checks++; if (dl !== 38401) begin errors++; $display("FAIL flip_throughput got=%0d want=38401", dl); end
    repeat (4) @(negedge clk);
    checks++; if (bus.oWrEn !== 1'b0 || bus.oDone !== 1'b1)
      begin errors++; $display("FAIL flip_ignored_go got=en %b done %b want=0 1", bus.oWrEn, bus.oDone); end
  endtask

  task automatic test_clip_reset();
    int dl, se, to, n;
    logic [25:0] e;
    run_prim(1'b0, 1'b1, 9'h123, 8'd238, 8'd159, 8'd242, 8'd159, 0, -1, dl, se, to);
    checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL clip_count got=%0d want=2", wr_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      e = {1'b0, 8'd159, 8'(238 + i), 9'h123};
      checks++; if (wr_q[i] !== e) begin errors++; $display("FAIL clip_px%0d got=%h want=%h", i, wr_q[i], e); end
    end
    checks++; if (dl !== 7) begin errors++; $display("FAIL clip_done_low got=%0d want=7", dl); end
    // Abort a long line with reset after ten accepted writes.
    @(negedge clk);
    bus.iGo = 1'b1; bus.iPolyline = 1'b1; bus.iColor = 9'h044;
    bus.iX0 = 8'd0; bus.iY0 = 8'd0; bus.iX1 = 8'd100; bus.iY1 = 8'd0;
    @(negedge clk);
    bus.iGo = 1'b0; bus.iPolyline = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      if (bus.oWrEn) n++;
      @(negedge clk);
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL abort_progress got=%0d want=10", n); end
    rst = 1'b1;
    #1;
    checks++; if (bus.oWrEn !== 1'b0) begin errors++; $display("FAIL abort_wren got=%b want=0", bus.oWrEn); end
    checks++; if (bus.oDone !== 1'b1) begin errors++; $display("FAIL abort_done got=%b want=1", bus.oDone); end
    checks++; if (bus.oFrontBuf !== 1'b0) begin errors++; $display("FAIL abort_front got=%b want=0", bus.oFrontBuf); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.oWrEn !== 1'b0 || bus.oDone !== 1'b1)
      begin errors++; $display("FAIL abort_quiet got=en %b done %b want=0 1", bus.oWrEn, bus.oDone); end
  endtask

  initial begin
    bus.iGo = 1'b0; bus.iFlip = 1'b0; bus.iPolyline = 1'b0; bus.iColor = '0;
    bus.iX0 = '0; bus.iY0 = '0; bus.iX1 = '0; bus.iY1 = '0; bus.iWrReady = 1'b1;
    test_reset();
    test_single_pixel();
    test_noop();
    test_horizontal();
    test_steep();
    test_random_lines(1000, 0);
    test_backpressure();
    test_flip();
    test_clip_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
